// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//
// Single-clock first-in first-out buffer with independent write and read
// enables. A producer pushes words when it has them and a consumer pulls them
// when it is ready. Every output comes straight from a flop.
//
// Parameters:
//   WIDTH     - bit width of stored words
//   DEPTH     - number of storage entries (power of two, >= 2)
//
// Ports:
//   clk       - posedge-active clock
//   rst       - synchronous, active-high reset; has priority over wr_en/rd_en
//   wr_en     - write request; accepted only when not full
//   din       - write data, sampled together with wr_en
//   rd_en     - read request; accepted only when not empty
//   dout      - read data, valid the cycle after an accepted read, held
//               until the next accepted read
//   full      - DEPTH words stored
//   empty     - zero words stored
//   count     - number of stored words, 0..DEPTH
//   overflow  - one-cycle pulse after an edge where wr_en was seen while full
//   underflow - one-cycle pulse after an edge where rd_en was seen while empty
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             wr_ok;
    logic             rd_ok;

    // Acceptance depends only on the registered flags, so a write at full is
    // refused even when a read frees a slot in the same cycle, and a read at
    // empty never falls through to the word being written.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_next = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: the storage array has no reset; after reset the pointers make
    // stale entries unreachable until they are rewritten, and leaving the
    // array unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            dout      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // Pointers are exactly AW bits wide, so DEPTH-1 wraps to 0.
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
                dout   <= mem[rd_ptr];
            end
            count     <= count_next;
            empty     <= (count_next == '0);
            full      <= (count_next == DEPTH_C);
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

endmodule
